// File: rtl/max_tracker_pkg.sv
// Shared definitions for max_tracker: state encoding and default geometry.
package max_tracker_pkg;

  localparam int DEFAULT_WIDTH  = 2;
  localparam int DEFAULT_WINDOW = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Index width: at least one bit even for a single-sample window.
  function automatic int idx_width(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/greater_than.sv
// Two-operand unsigned comparator: F is high when A is strictly greater than B.
module greater_than #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             F
);

  assign F = (A > B);

endmodule

// File: rtl/max_tracker.sv
// Windowed maximum tracker: collects WINDOW accepted samples, then holds the
// largest value and the position of its first occurrence until downstream takes it.
module max_tracker
  import max_tracker_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int WINDOW = DEFAULT_WINDOW,
  localparam int IDXW   = idx_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0]  out_idx,
  output logic             new_max
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  count_q, count_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             new_max_q, new_max_d;
  logic             accept;
  logic             gt;

  greater_than #(.WIDTH(WIDTH)) u_gt (
    .A(in_data),
    .B(max_q),
    .F(gt)
  );

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign new_max   = new_max_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    idx_d     = idx_q;
    new_max_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          // The first sample of a window seeds the running max unconditionally.
          if ((count_q == '0) || gt) begin
            max_d     = in_data;
            idx_d     = count_q;
            new_max_d = 1'b1;
          end
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = HOLD;
          end else begin
            count_d = count_q + IDXW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      new_max_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      new_max_q <= new_max_d;
    end
  end

endmodule

// File: tb/tb_max_tracker.sv
// Scoreboard bench: a WINDOW=4 and a WINDOW=1 tracker share one stimulus stream;
// a behavioural model queues expected results and checks every handshake.
module tb_max_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       out_ready;

  logic       ir0, ov0, nm0;
  logic [1:0] om0, oi0;
  logic       ir1, ov1, nm1;
  logic [1:0] om1;
  logic [0:0] oi1;

  always #5 clk = ~clk;

  max_tracker #(.WIDTH(2), .WINDOW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_max(om0), .out_idx(oi0), .new_max(nm0)
  );

  max_tracker #(.WIDTH(2), .WINDOW(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_max(om1), .out_idx(oi1), .new_max(nm1)
  );

  typedef struct {
    int mx;
    int ix;
  } res_t;

  res_t q0[$];
  res_t q1[$];

  int total = 0;
  int bad   = 0;

  // Model state per DUT (0 = WINDOW 4, 1 = WINDOW 1); ms: 0 collect, 1 hold.
  int win[2] = '{4, 1};
  int ms[2];
  int cnt[2];
  int mx[2];
  int ix[2];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int get_ir(input int d);
    return (d == 0) ? int'(ir0) : int'(ir1);
  endfunction
  function automatic int get_ov(input int d);
    return (d == 0) ? int'(ov0) : int'(ov1);
  endfunction
  function automatic int get_nm(input int d);
    return (d == 0) ? int'(nm0) : int'(nm1);
  endfunction
  function automatic int get_om(input int d);
    return (d == 0) ? int'(om0) : int'(om1);
  endfunction
  function automatic int get_oi(input int d);
    return (d == 0) ? int'(oi0) : int'(oi1);
  endfunction

  // One clock of stimulus; inputs are driven just after a falling edge.
  task automatic step(input bit v, input int data, input bit r);
    int   enm[2];
    int   qs;
    res_t e;
    in_valid  = v;
    in_data   = data[1:0];
    out_ready = r;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("in_ready%0d", d), get_ir(d), (ms[d] == 0) ? 1 : 0);
      chk($sformatf("out_valid%0d", d), get_ov(d), (ms[d] == 1) ? 1 : 0);
      enm[d] = 0;
      if (ms[d] == 1) begin
        qs = (d == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          chk($sformatf("unexpected_result%0d", d), 1, 0);
        end else begin
          e = (d == 0) ? q0[0] : q1[0];
          chk($sformatf("out_max%0d", d), get_om(d), e.mx);
          chk($sformatf("out_idx%0d", d), get_oi(d), e.ix);
          if (r) begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            $display("result dut%0d: max=%0d idx=%0d", d, e.mx, e.ix);
          end
        end
        if (r) ms[d] = 0;
      end else if (v) begin
        if (cnt[d] == 0 || data > mx[d]) begin
          mx[d]  = data;
          ix[d]  = cnt[d];
          enm[d] = 1;
        end
        if (cnt[d] == win[d] - 1) begin
          e.mx = mx[d];
          e.ix = ix[d];
          if (d == 0) q0.push_back(e);
          else        q1.push_back(e);
          ms[d]  = 1;
          cnt[d] = 0;
        end else begin
          cnt[d]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("new_max%0d", d), get_nm(d), enm[d]);
    end
    @(negedge clk);
  endtask

  // Reset with the given inputs held active to show reset wins over them.
  task automatic do_reset(input bit v, input bit r);
    rst       = 1'b1;
    in_valid  = v;
    in_data   = 2'd3;
    out_ready = r;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ms[d] = 0; cnt[d] = 0; mx[d] = 0; ix[d] = 0;
      chk($sformatf("rst_out_valid%0d", d), get_ov(d), 0);
      chk($sformatf("rst_in_ready%0d", d), get_ir(d), 1);
      chk($sformatf("rst_new_max%0d", d), get_nm(d), 0);
      chk($sformatf("rst_out_max%0d", d), get_om(d), 0);
      chk($sformatf("rst_out_idx%0d", d), get_oi(d), 0);
    end
    q0.delete();
    q1.delete();
    $display("reset applied (in_valid=%0d out_ready=%0d)", v, r);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    // 1,3,2,3 back-to-back; WINDOW=1 takes every other sample.
    step(1, 1, 1); step(1, 3, 1); step(1, 2, 1); step(1, 3, 1);
    step(0, 0, 1);

    // Rising ramp, then a long stall in HOLD with valid data waiting.
    step(1, 0, 1); step(1, 1, 1); step(1, 2, 1); step(1, 3, 1);
    for (int i = 0; i < 5; i++) step(1, 3, 0);
    step(1, 3, 1);

    // All-equal window keeps the earliest index.
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
    step(0, 0, 1);

    // Idle gaps between samples.
    step(1, 2, 1); step(0, 1, 1); step(0, 3, 1); step(1, 1, 1);
    step(0, 2, 1); step(1, 0, 1); step(1, 3, 1);
    step(0, 0, 1);

    // Abort a partial window, then a clean one.
    step(1, 3, 1); step(1, 3, 1);
    do_reset(1'b1, 1'b1);
    step(1, 1, 1); step(1, 0, 1); step(1, 2, 1); step(1, 0, 1);
    step(0, 0, 1);

    // Single-sample windows with 2 then 1.
    step(1, 2, 0); step(0, 0, 1); step(1, 1, 0); step(0, 0, 1);
    step(0, 0, 1); step(0, 0, 1);

    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_tracker.md
MAX_TRACKER -- requirements
Module: max_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning the operand width in bits and matching the comparator operand width.
REQ-002 SHALL have parameter WINDOW, default 4, meaning the number of samples per result window (legal range 1..256).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the upstream sample is present.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits, the unsigned sample.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning the window result is present.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning downstream takes the result.
REQ-010 SHALL have port out_max, output, WIDTH bits, the largest sample in the window.
REQ-011 SHALL have port out_idx, output, IDXW = max(1, clog2(WINDOW)) bits, the 0-based position of the first occurrence of out_max.
REQ-012 SHALL have port new_max, output, 1 bit, a one-cycle pulse meaning the running maximum was just updated.

Function
REQ-013 SHALL accept a sample only on a cycle with in_valid=1 and in_ready=1 (an accept); no other input cycle has any effect.
REQ-014 SHALL implement a two-state FSM: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL, on the first accept of a window (count=0), load the running max from in_data and the running index with 0 unconditionally.
REQ-016 SHALL, on each later accept, replace the running max with in_data and the running index with count only when in_data > running max (strict unsigned compare).
REQ-017 SHALL therefore keep the earliest index when samples are equal.
REQ-018 SHALL increment count on every accept.
REQ-019 SHALL move from COLLECT to HOLD on the accept with count=WINDOW-1, so out_valid rises the cycle after the last sample (latency 1).
REQ-020 SHALL, in HOLD, hold out_max and out_idx stable and ignore in_data and in_valid.
REQ-021 SHALL, in HOLD with out_ready=1, return to COLLECT the next cycle with count=0; out_ready is ignored in COLLECT.
REQ-022 SHALL register new_max=1 for exactly one cycle after any accept that loaded or updated the max, including the first sample of a window, and hold it at 0 otherwise.
REQ-023 SHALL, with WINDOW=1, enter HOLD after every single accept with out_idx=0 and new_max=1.
REQ-024 SHALL require in_data to be unchanged by upstream until its accept; it is not required to store unaccepted data.

Reset
REQ-025 SHALL, on a clk edge with rst=1, force state=COLLECT, count=0, running max=0, index=0, out_valid=0, new_max=0, and out_max=0 and out_idx=0.
REQ-026 SHALL, when rst is asserted mid-window or in HOLD, discard the partial window or pending result, with no output produced for it.
REQ-027 SHALL have rst take priority over a simultaneous accept or out_ready.

Structure
REQ-028 SHALL place the state encoding (COLLECT=0, HOLD=1) and the default WIDTH/WINDOW values in a shared package/include, max_tracker_pkg.
REQ-029 SHALL perform the compare of REQ-016 by instantiating the existing two-operand greater_than comparator as its only sub-module (A=in_data, B=running max, F drives the update).
REQ-030 SHALL contain no other arithmetic besides the count incrementer.

Verification (WIDTH=2, WINDOW=4)
REQ-031 SHALL cover samples 1,3,2,3 back-to-back -> out_max=3, out_idx=1, new_max pulses after samples 0 and 1 only, out_valid rises 1 cycle after the 4th accept.
REQ-032 SHALL cover samples 0,1,2,3 -> four new_max pulses, out_max=3, out_idx=3; and samples 0,0,0,0 -> out_max=0, out_idx=0, one new_max pulse.
REQ-033 SHALL cover out_ready held low for 5 cycles in HOLD while in_valid=1 with data 3 -> in_ready=0, out_max/out_idx unchanged, then one out_ready cycle -> COLLECT with count=0.
REQ-034 SHALL cover in_valid gaps (samples 2,_,_,1,_,0,3) -> result out_max=3, out_idx=3, unaffected by the idle cycles.
REQ-035 SHALL cover rst for one cycle after 2 accepts (3,3) and then samples 1,0,2,0 -> out_max=2, out_idx=2, with no result for the aborted window.
REQ-036 SHALL cover WINDOW=1 with samples 2 then 1 -> two results, (2,0) then (1,0).
